reg_file: RTL and testbench



---
 rtl/reg_file_if.sv | 21 ++
 rtl/reg_file.sv | 58 +++++
 tb/tb_reg_file.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - read/write bus between the pipeline and the register file
interface reg_file_if;
  logic [4:0]  RSaddr_i;
  logic [4:0]  RTaddr_i;
  logic [4:0]  RDaddr_i;
  logic [31:0] RDdata_i;
  logic        RegWrite_i;
  logic [31:0] RSdata_o;
  logic [31:0] RTdata_o;
  logic [15:0] wr_cnt_o;

  modport master (
    output RSaddr_i, RTaddr_i, RDaddr_i, RDdata_i, RegWrite_i,
    input  RSdata_o, RTdata_o, wr_cnt_o
  );

  modport slave (
    input  RSaddr_i, RTaddr_i, RDaddr_i, RDdata_i, RegWrite_i,
    output RSdata_o, RTdata_o, wr_cnt_o
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two combinational read ports, one write port
// Define REG_FILE_BYPASS_EN to make a same-cycle write visible on the read ports.
module reg_file #(
  parameter logic [31:0] SP_RESET = 32'd0
) (
  input logic       clk_i,
  input logic       rst_i,
  reg_file_if.slave bus
);
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam logic [4:0] SP_REG   = 5'd29;

  logic [31:0] regs [32];
  logic [15:0] wr_cnt;
  logic        commit;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  assign commit = bus.RegWrite_i && (bus.RDaddr_i != ZERO_REG);

  // Entry 0 is kept at zero as well, but the read muxes never rely on it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (5'(i) == SP_REG) ? SP_RESET : 32'd0;
      end
      wr_cnt <= 16'd0;
    end else if (commit) begin
      regs[bus.RDaddr_i] <= bus.RDdata_i;
      wr_cnt             <= wr_cnt + 16'd1;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic bypass;
  assign bypass = commit && !rst_i;
`endif

  always_comb begin
    rs_data = regs[bus.RSaddr_i];
`ifdef REG_FILE_BYPASS_EN
    if (bypass && (bus.RSaddr_i == bus.RDaddr_i)) rs_data = bus.RDdata_i;
`endif
    if (bus.RSaddr_i == ZERO_REG) rs_data = 32'd0;
  end

  always_comb begin
    rt_data = regs[bus.RTaddr_i];
`ifdef REG_FILE_BYPASS_EN
    if (bypass && (bus.RTaddr_i == bus.RDaddr_i)) rt_data = bus.RDdata_i;
`endif
    if (bus.RTaddr_i == ZERO_REG) rt_data = 32'd0;
  end

  assign bus.RSdata_o = rs_data;
  assign bus.RTdata_o = rt_data;
  assign bus.wr_cnt_o = wr_cnt;
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file against an array reference model
module tb_reg_file;
  localparam logic [31:0] SP_VAL = 32'd128;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  reg_file_if bus ();

  reg_file #(.SP_RESET(SP_VAL)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [32];
  int unsigned wcount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[29] = SP_VAL;
    wcount = 0;
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a, input logic [4:0] rd,
                                             input logic [31:0] d, input logic we);
    if (a == 5'd0) return 32'd0;
`ifdef REG_FILE_BYPASS_EN
    if (we && rd == a) return d;
`endif
    return model[a];
  endfunction

  // One bus cycle: reads checked before the edge, the commit and counter after it.
  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] d, input logic we);
    @(negedge clk_i);
    bus.RSaddr_i   = rs;
    bus.RTaddr_i   = rt;
    bus.RDaddr_i   = rd;
    bus.RDdata_i   = d;
    bus.RegWrite_i = we;
    #1;
    check("rs_read", bus.RSdata_o, expect_rd(rs, rd, d, we));
    check("rt_read", bus.RTdata_o, expect_rd(rt, rd, d, we));
    if (rs == rt) check("same_index", bus.RTdata_o, bus.RSdata_o);
    @(posedge clk_i);
    #1;
    if (we && rd != 5'd0) begin
      model[rd] = d;
      wcount++;
    end
    check("wr_cnt", {16'd0, bus.wr_cnt_o}, wcount & 32'hFFFF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0]  rs, rt, rd;
    logic [31:0] d;
    logic        we;

    bus.RSaddr_i   = 5'd29;
    bus.RTaddr_i   = 5'd5;
    bus.RDaddr_i   = 5'd0;
    bus.RDdata_i   = 32'd0;
    bus.RegWrite_i = 1'b0;

    // Asynchronous reset, before any clock edge
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check("reset_sp", bus.RSdata_o, 32'd128);
    check("reset_r5", bus.RTdata_o, 32'd0);
    check("reset_cnt", {16'd0, bus.wr_cnt_o}, 32'd0);

    // Write attempted while reset is held
    bus.RDaddr_i   = 5'd5;
    bus.RDdata_i   = 32'hAAAA_5555;
    bus.RegWrite_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_block_r5", bus.RTdata_o, 32'd0);
    check("rst_block_cnt", {16'd0, bus.wr_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    bus.RegWrite_i = 1'b0;

    // Write of reg 8, then read back on both ports
    step(5'd8, 5'd8, 5'd8, 32'hDEAD_BEEF, 1'b1);
    check("r8_rs_next", bus.RSdata_o, 32'hDEAD_BEEF);
    check("r8_rt_next", bus.RTdata_o, 32'hDEAD_BEEF);
    check("r8_cnt", {16'd0, bus.wr_cnt_o}, 32'd1);

    // Write to index 0 is discarded
    step(5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    check("r0_after", bus.RSdata_o, 32'd0);
    check("r0_cnt", {16'd0, bus.wr_cnt_o}, 32'd1);

    // Disabled write leaves reg 3 alone
    step(5'd3, 5'd3, 5'd3, 32'h5, 1'b0);
    check("r3_nowrite", bus.RSdata_o, 32'd0);

    // Reset raised mid-cycle during a write of reg 4
    @(negedge clk_i);
    bus.RSaddr_i   = 5'd4;
    bus.RTaddr_i   = 5'd8;
    bus.RDaddr_i   = 5'd4;
    bus.RDdata_i   = 32'h7;
    bus.RegWrite_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check("midrst_r4", bus.RSdata_o, 32'd0);
    check("midrst_r8", bus.RTdata_o, 32'd0);
    check("midrst_cnt", {16'd0, bus.wr_cnt_o}, 32'd0);
    @(posedge clk_i);
    #1;
    check("midrst_r4_edge", bus.RSdata_o, 32'd0);
    check("midrst_cnt_edge", {16'd0, bus.wr_cnt_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    bus.RegWrite_i = 1'b0;

    // First edge after reset accepts a write
    step(5'd4, 5'd29, 5'd4, 32'h7, 1'b1);
    check("post_rst_r4", bus.RSdata_o, 32'h7);
    check("post_rst_sp", bus.RTdata_o, 32'd128);

    // Counter wrap: 65537 committed writes from a fresh reset
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int n = 0; n < 65537; n++) begin
      rd = 5'($urandom_range(31, 1));
      d  = $urandom;
      bus.RDaddr_i   = rd;
      bus.RDdata_i   = d;
      bus.RegWrite_i = 1'b1;
      @(posedge clk_i);
      model[rd] = d;
      wcount++;
      @(negedge clk_i);
    end
    bus.RegWrite_i = 1'b0;
    #1;
    check("wrap_cnt", {16'd0, bus.wr_cnt_o}, 32'h0001);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      rs = 5'($urandom_range(31, 0));
      rt = ($urandom_range(3, 0) == 0) ? rs : 5'($urandom_range(31, 0));
      rd = ($urandom_range(7, 0) == 0) ? rs : 5'($urandom_range(31, 0));
      we = 1'($urandom_range(1, 0));
      d  = (!we && $urandom_range(1, 0) == 1) ? 32'bx : $urandom;
      step(rs, rt, rd, d, we);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
